command_driver: RTL

Transmit-side driver for the command bus into the DDR2 controller: takes transaction requests from the stimulus generator, buffers block-write data, and presents `cmd`/`sz`/`op`/`din`/`addr` to the controller, pacing every command and data beat on `fetching`. It is the initiator on the bus that `command_monitor` observes, so every value it drives must satisfy that monitor's legality checks.

---
 rtl/ddr2_cmd_pkg.sv | 53 +++++
 rtl/cmd_blk_buffer.sv | 39 +++
 rtl/command_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2_cmd_pkg
//  Description : Shared definitions for the DDR2 command bus: command codes,
//                driver FSM states, field widths, address field positions
//                and the block-length helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ddr2_cmd_pkg;

    localparam int CMD_W  = 3;
    localparam int SZ_W   = 2;
    localparam int OP_W   = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 25;
    localparam int PTR_W  = 5;   // block-buffer pointer width (32 words max)
    localparam int CNT_W  = 6;   // wide enough to hold a block length of 32

    // Address layout: {row, col[9:3], bank, col[2:0]}
    localparam int ROW_MSB  = 24;
    localparam int ROW_LSB  = 12;
    localparam int COLH_MSB = 11;
    localparam int COLH_LSB = 5;
    localparam int BANK_MSB = 4;
    localparam int BANK_LSB = 3;
    localparam int COLL_MSB = 2;
    localparam int COLL_LSB = 0;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_NOP7 = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_BLKWR = 2'd3
    } state_e;

    // Block length in words: 8 * (sz + 1)
    function automatic logic [CNT_W-1:0] blk_words(input logic [SZ_W-1:0] sz);
        return {1'b0, sz, 3'b000} + CNT_W'(8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_blk_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_blk_buffer
//  Description : DEPTH x WIDTH register array holding one block-write burst.
//                One synchronous write port, one asynchronous read port.
//  Revision    : 1.0  initial release
//  Ports       : clk        - clock
//                wr_en_i    - write strobe
//                wr_addr_i  - write pointer
//                wr_data_i  - write word
//                rd_addr_i  - read pointer
//                rd_data_o  - word at rd_addr_i
// ============================================================================
module cmd_blk_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/command_driver.sv
`default_nettype none
// ============================================================================
//  Module      : command_driver
//  Description : Transmit-side driver for the DDR2 controller command bus.
//                Accepts request headers, buffers block-write data, and
//                presents cmd/sz/op/din/addr, advancing on each fetching edge.
//  Revision    : 1.0  initial release
//  Macro       : CMD_DRIVER_STATS_EN - adds stat_cmds / stat_beats counters
//  Ports       : clk, reset (async, active-low)
//                req_valid/req_ready + req_cmd/sz/op/addr/data - header in
//                wd_valid/wd_ready + wd_data - block-write data in
//                fetching - controller consumes current command/beat
//                cmd, sz, op, din, addr - registered command bus out
//                busy - FSM not idle
// ============================================================================
module command_driver
    import ddr2_cmd_pkg::*;
#(
    parameter int BLK_MAX = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [SZ_W-1:0]   req_sz,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic              fetching,
    output logic [CMD_W-1:0]  cmd,
    output logic [SZ_W-1:0]   sz,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
`ifdef CMD_DRIVER_STATS_EN
    ,
    output logic [15:0]       stat_cmds,
    output logic [15:0]       stat_beats
`endif
);

    state_e              state_q, state_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [SZ_W-1:0]     sz_q, sz_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_ready_q, req_ready_d;
    // BLW header is parked here while the block loads; the bus stays NOP.
    logic [SZ_W-1:0]     hdr_sz_q, hdr_sz_d;
    logic [ADDR_W-1:0]   hdr_addr_q, hdr_addr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;   // index of the word now on din

    logic                buf_we;
    logic [PTR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic [CNT_W-1:0]    blk_len;
    logic [PTR_W-1:0]    last_idx;

    assign blk_len  = blk_words(hdr_sz_q);
    assign last_idx = PTR_W'(blk_len - CNT_W'(1));
    // While loading, the read port looks at word 0 so it is ready for the
    // header beat; afterwards it pre-fetches the word after the current one.
    assign rd_addr  = (state_q == ST_LOAD) ? '0 : rptr_q + PTR_W'(1);

    cmd_blk_buffer #(
        .DEPTH (BLK_MAX),
        .WIDTH (DATA_W),
        .AW    (PTR_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (wptr_q),
        .wr_data_i (wd_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            sz_q        <= '0;
            op_q        <= '0;
            din_q       <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            hdr_sz_q    <= '0;
            hdr_addr_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            sz_q        <= sz_d;
            op_q        <= op_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            hdr_sz_q    <= hdr_sz_d;
            hdr_addr_q  <= hdr_addr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        sz_d       = sz_q;
        op_d       = op_q;
        din_d      = din_q;
        addr_d     = addr_q;
        hdr_sz_d   = hdr_sz_q;
        hdr_addr_d = hdr_addr_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        buf_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    case (req_cmd)
                        CMD_NOP, CMD_NOP7: begin
                            // dropped
                        end
                        CMD_BLW: begin
                            hdr_sz_d   = req_sz;
                            hdr_addr_d = req_addr;
                            wptr_d     = '0;
                            rptr_d     = '0;
                            state_d    = ST_LOAD;
                        end
                        default: begin
                            cmd_d   = req_cmd;
                            sz_d    = req_sz;
                            addr_d  = req_addr;
                            op_d    = (req_cmd == CMD_ATR || req_cmd == CMD_ATW) ? req_op : '0;
                            din_d   = (req_cmd == CMD_SCR || req_cmd == CMD_BLR) ? '0 : req_data;
                            state_d = ST_ISSUE;
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                if (wd_valid) begin
                    buf_we = 1'b1;
                    wptr_d = wptr_q + PTR_W'(1);
                    if (wptr_q == last_idx) begin
                        // Word 0 was written on an earlier cycle (blocks are
                        // at least 8 words), so it is already readable.
                        cmd_d   = CMD_BLW;
                        sz_d    = hdr_sz_q;
                        addr_d  = hdr_addr_q;
                        op_d    = '0;
                        din_d   = rd_data;
                        rptr_d  = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (fetching) begin
                    if (cmd_q == CMD_BLW) begin
                        cmd_d   = CMD_NOP;
                        din_d   = rd_data;
                        rptr_d  = rptr_q + PTR_W'(1);
                        state_d = ST_BLKWR;
                    end else begin
                        cmd_d   = '0;
                        sz_d    = '0;
                        op_d    = '0;
                        din_d   = '0;
                        addr_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_BLKWR: begin
                if (fetching) begin
                    if (rptr_q == last_idx) begin
                        cmd_d   = '0;
                        sz_d    = '0;
                        op_d    = '0;
                        din_d   = '0;
                        addr_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        din_d   = rd_data;
                        rptr_d  = rptr_q + PTR_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready = req_ready_q;
    assign wd_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign cmd       = cmd_q;
    assign sz        = sz_q;
    assign op        = op_q;
    assign din       = din_q;
    assign addr      = addr_q;

`ifdef CMD_DRIVER_STATS_EN
    logic [15:0] stat_cmds_q;
    logic [15:0] stat_beats_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cmds_q  <= '0;
            stat_beats_q <= '0;
        end else begin
            if (state_q == ST_ISSUE && fetching && stat_cmds_q != 16'hFFFF) begin
                stat_cmds_q <= stat_cmds_q + 16'd1;
            end
            if (state_q == ST_BLKWR && fetching && stat_beats_q != 16'hFFFF) begin
                stat_beats_q <= stat_beats_q + 16'd1;
            end
        end
    end

    assign stat_cmds  = stat_cmds_q;
    assign stat_beats = stat_beats_q;
`endif

endmodule
`default_nettype wire
